// File: rtl/data_mem_unit.sv
// Data memory unit: in-order request FIFO feeding a fixed-latency word memory.
// Optional DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into no-op traps.
module data_mem_unit #(
  parameter int ADDR_W     = 10,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [31:0] reqPc,
  input  logic [31:0] reqAddr,
  input  logic        reqStore,
  input  logic [1:0]  reqSize,
  input  logic        reqUnsigned,
  input  logic [31:0] reqData,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respPc,
  output logic        respStore,
  output logic [31:0] respData,
  output logic        respMisalign,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic        store;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  req_t          fifo_q [FIFO_DEPTH];
  req_t          cur_q;
  req_t          req_in;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic [3:0]    ctr_q;
  logic          push, pop, access, do_write;

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rword, shifted, wd, load;
  logic [15:0]       hv;
  logic [3:0]        be;
  logic [1:0]        lane;
  logic              mis, is_byte, is_half, is_word;
  logic              unused_addr;

  assign req_in = '{pc: reqPc, addr: reqAddr, store: reqStore,
                    size: reqSize, uns: reqUnsigned, data: reqData};

  assign reqReady  = count_q < CW'(FIFO_DEPTH);
  assign push      = reqValid && reqReady;
  assign respValid = state_q == RESP;
  assign busy      = (state_q != IDLE) || (count_q != '0);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      IDLE: if (count_q != '0) begin
        pop     = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (ctr_q == 4'd0) begin
        access  = 1'b1;
        state_d = RESP;
      end
      RESP: if (respReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign is_byte     = cur_q.size == 2'b00;
  assign is_half     = cur_q.size == 2'b01;
  assign is_word     = cur_q.size[1];
  assign idx         = cur_q.addr[ADDR_W+1:2];
  assign rword       = mem[idx];
  assign unused_addr = ^cur_q.addr[31:ADDR_W+2];

  always_comb begin
    lane = cur_q.addr[1:0];
    mis  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (is_half && lane[0]) || (is_word && lane != 2'b00);
`else
    if (is_half) lane[0] = 1'b0;
    if (is_word) lane    = 2'b00;
`endif
  end

  // Store lanes are replicated so the byte enables alone select the target
  always_comb begin
    be      = 4'b0000;
    wd      = cur_q.data;
    load    = rword;
    hv      = lane[1] ? rword[31:16] : rword[15:0];
    shifted = rword >> {lane, 3'b000};
    unique case (1'b1)
      is_byte: begin
        be   = 4'b0001 << lane;
        wd   = {4{cur_q.data[7:0]}};
        load = cur_q.uns ? {24'd0, shifted[7:0]}
                         : {{24{shifted[7]}}, shifted[7:0]};
      end
      is_half: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wd   = {2{cur_q.data[15:0]}};
        load = cur_q.uns ? {16'd0, hv} : {{16{hv[15]}}, hv};
      end
      is_word: begin
        be   = 4'b1111;
        wd   = cur_q.data;
        load = rword;
      end
      default: be = 4'b0000;
    endcase
  end

  assign do_write = access && cur_q.store && !mis;

  always_ff @(posedge clk) begin
    if (rstn && do_write) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      ctr_q        <= 4'd0;
      respPc       <= 32'd0;
      respStore    <= 1'b0;
      respData     <= 32'd0;
      respMisalign <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_q + CW'(push) - CW'(pop);
      if (push) begin
        fifo_q[wptr_q] <= req_in;
        wptr_q         <= wptr_q + 1'b1;
      end
      if (pop) begin
        cur_q  <= fifo_q[rptr_q];
        rptr_q <= rptr_q + 1'b1;
        ctr_q  <= 4'(LATENCY - 1);
      end else if (state_q == WAIT && ctr_q != 4'd0) begin
        ctr_q <= ctr_q - 4'd1;
      end
      if (access) begin
        respPc       <= cur_q.pc;
        respStore    <= cur_q.store;
        respData     <= (cur_q.store || mis) ? 32'd0 : load;
        respMisalign <= mis;
      end
    end
  end

endmodule
